// File: rtl/cpu16_fetch.sv
// Instruction fetch stage: holds the PC, reads IMEM over req/ack, hands IR to decode.
// Optional halt-on-opcode-F support is enabled by defining CPU16_FETCH_HALT_EN.
module cpu16_fetch #(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              PC_STEP  = 1
) (
  input  logic            CLK,
  input  logic            RST_N,
  output logic            IMEM_REQ,
  output logic [PC_W-1:0] IMEM_ADDR,
  input  logic            IMEM_ACK,
  input  logic [15:0]     IMEM_RDATA,
  output logic [15:0]     IR,
  output logic            IR_VALID,
  input  logic            IR_READY,
  input  logic            BR_TAKE,
  input  logic [PC_W-1:0] BR_TARGET,
  output logic [PC_W-1:0] PC_OUT
);

  localparam logic [PC_W-1:0] STEP = PC_W'(PC_STEP);

`ifdef CPU16_FETCH_HALT_EN
  typedef enum logic [1:0] {S_REQ, S_HOLD, S_HALT} state_t;
`else
  typedef enum logic [1:0] {S_REQ, S_HOLD} state_t;
`endif

  state_t          r_state;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] r_pc_out;
  logic [15:0]     r_ir;
  logic            r_ir_valid;

  logic            w_req;
  logic            w_ack;
  logic            w_accept;

  // NOTE: the request is masked while RST_N is low so a reset cycle never
  // advertises a fetch, and a late ACK for an abandoned request is ignored.
  assign w_req    = RST_N && (r_state == S_REQ);
  assign w_ack    = IMEM_ACK && w_req;
  assign w_accept = r_ir_valid && IR_READY;

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values of its peers, independent of statement order.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state    <= S_REQ;
      r_pc       <= RESET_PC;
      r_pc_out   <= RESET_PC;
      r_ir       <= 16'h0000;
      r_ir_valid <= 1'b0;
    end else if (BR_TAKE) begin
      // A redirect drops any same-cycle ACK or handshake.
      r_pc       <= BR_TARGET;
      r_ir_valid <= 1'b0;
      r_state    <= S_REQ;
    end else begin
      case (r_state)
        S_REQ: begin
          if (w_ack) begin
            r_ir       <= IMEM_RDATA;
            r_ir_valid <= 1'b1;
            r_pc_out   <= r_pc;
            r_pc       <= r_pc + STEP;
            r_state    <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (w_accept) begin
            r_ir_valid <= 1'b0;
`ifdef CPU16_FETCH_HALT_EN
            r_state    <= (r_ir[15:12] == 4'hF) ? S_HALT : S_REQ;
`else
            r_state    <= S_REQ;
`endif
          end
        end
`ifdef CPU16_FETCH_HALT_EN
        S_HALT: begin
          r_ir_valid <= 1'b0;
        end
`endif
        default: begin
          r_state    <= S_REQ;
          r_ir_valid <= 1'b0;
        end
      endcase
    end
  end

  assign IMEM_REQ  = w_req;
  assign IMEM_ADDR = r_pc;
  assign IR        = r_ir;
  assign IR_VALID  = r_ir_valid;
  assign PC_OUT    = r_pc_out;

endmodule

// File: tb/tb_cpu16_fetch.sv
// Directed bench for cpu16_fetch: two instances (RESET_PC=0000 and FFFF) share stimulus.
// Covers reset, streaming, wait states, decode stall, branch flush, opcode F and wrap.
module tb_cpu16_fetch;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        IMEM_ACK = 1'b0;
  logic [15:0] IMEM_RDATA = 16'h0000;
  logic        IR_READY = 1'b0;
  logic        BR_TAKE = 1'b0;
  logic [15:0] BR_TARGET = 16'h0000;

  logic        req, w_req;
  logic [15:0] addr, w_addr;
  logic [15:0] ir, w_ir;
  logic        ir_valid, w_ir_valid;
  logic [15:0] pc_out, w_pc_out;

  int errors = 0;
  int checks = 0;

  cpu16_fetch #(.PC_W(16), .RESET_PC(16'h0000), .PC_STEP(1)) u_dut (
    .CLK(CLK), .RST_N(RST_N), .IMEM_REQ(req), .IMEM_ADDR(addr),
    .IMEM_ACK(IMEM_ACK), .IMEM_RDATA(IMEM_RDATA), .IR(ir), .IR_VALID(ir_valid),
    .IR_READY(IR_READY), .BR_TAKE(BR_TAKE), .BR_TARGET(BR_TARGET), .PC_OUT(pc_out)
  );

  cpu16_fetch #(.PC_W(16), .RESET_PC(16'hFFFF), .PC_STEP(1)) u_dut_wrap (
    .CLK(CLK), .RST_N(RST_N), .IMEM_REQ(w_req), .IMEM_ADDR(w_addr),
    .IMEM_ACK(IMEM_ACK), .IMEM_RDATA(IMEM_RDATA), .IR(w_ir), .IR_VALID(w_ir_valid),
    .IR_READY(IR_READY), .BR_TAKE(BR_TAKE), .BR_TARGET(BR_TARGET), .PC_OUT(w_pc_out)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    #1;
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL reset_req_pre got=%b exp=0", req); end
    step();
    step();
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", req); end
    checks++; if (ir !== 16'h0000) begin errors++; $display("FAIL reset_ir got=%h exp=0000", ir); end
    checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", ir_valid); end
    checks++; if (pc_out !== 16'h0000) begin errors++; $display("FAIL reset_pc_out got=%h exp=0000", pc_out); end
    RST_N = 1'b1;
    #1;
    checks++; if (req !== 1'b1) begin errors++; $display("FAIL release_req got=%b exp=1", req); end
    checks++; if (addr !== 16'h0000) begin errors++; $display("FAIL release_addr got=%h exp=0000", addr); end
    checks++; if (w_addr !== 16'hFFFF) begin errors++; $display("FAIL release_wrap_addr got=%h exp=FFFF", w_addr); end
  endtask

  task automatic test_stream();
    logic [15:0] words [4];
    words[0] = 16'h02A2; words[1] = 16'h0222; words[2] = 16'h02C2; words[3] = 16'h02E2;
    IR_READY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      IMEM_ACK = 1'b1;
      IMEM_RDATA = words[i];
      step();
      IMEM_ACK = 1'b0;
      checks++; if (ir_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got=%b exp=1", i, ir_valid); end
      checks++; if (ir !== words[i]) begin errors++; $display("FAIL stream_ir[%0d] got=%h exp=%h", i, ir, words[i]); end
      checks++; if (pc_out !== 16'(i)) begin errors++; $display("FAIL stream_pc_out[%0d] got=%h exp=%h", i, pc_out, 16'(i)); end
      checks++; if (req !== 1'b0) begin errors++; $display("FAIL stream_req_hold[%0d] got=%b exp=0", i, req); end
      step();
      checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL stream_consumed[%0d] got=%b exp=0", i, ir_valid); end
      checks++; if (req !== 1'b1 || addr !== 16'(i + 1)) begin
        errors++; $display("FAIL stream_next_req[%0d] got=%b/%h exp=1/%h", i, req, addr, 16'(i + 1));
      end
    end
  endtask

  task automatic test_wait_state();
    IR_READY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (req !== 1'b1 || addr !== 16'h0004 || ir_valid !== 1'b0) begin
        errors++; $display("FAIL wait_stable[%0d] got=%b/%h/%b exp=1/0004/0", i, req, addr, ir_valid);
      end
    end
    IMEM_ACK = 1'b1;
    IMEM_RDATA = 16'h02A2;
    step();
    IMEM_ACK = 1'b0;
    checks++; if (ir_valid !== 1'b1 || ir !== 16'h02A2) begin
      errors++; $display("FAIL wait_capture got=%b/%h exp=1/02A2", ir_valid, ir);
    end
    checks++; if (pc_out !== 16'h0004) begin errors++; $display("FAIL wait_pc_out got=%h exp=0004", pc_out); end
  endtask

  task automatic test_stall();
    IMEM_RDATA = 16'h5555;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (ir !== 16'h02A2 || ir_valid !== 1'b1 || pc_out !== 16'h0004) begin
        errors++; $display("FAIL stall_hold[%0d] got=%h/%b/%h exp=02A2/1/0004", i, ir, ir_valid, pc_out);
      end
      checks++; if (req !== 1'b0 || addr !== 16'h0005) begin
        errors++; $display("FAIL stall_req[%0d] got=%b/%h exp=0/0005", i, req, addr);
      end
    end
    IR_READY = 1'b1;
    step();
    checks++; if (ir_valid !== 1'b0 || req !== 1'b1 || addr !== 16'h0005) begin
      errors++; $display("FAIL stall_release got=%b/%b/%h exp=0/1/0005", ir_valid, req, addr);
    end
  endtask

  task automatic test_branch();
    IMEM_ACK = 1'b1;
    IMEM_RDATA = 16'hBEEF;
    BR_TAKE = 1'b1;
    BR_TARGET = 16'h0040;
    step();
    IMEM_ACK = 1'b0;
    BR_TAKE = 1'b0;
    checks++; if (ir_valid !== 1'b0 || ir !== 16'h02A2) begin
      errors++; $display("FAIL branch_drop got=%b/%h exp=0/02A2", ir_valid, ir);
    end
    checks++; if (req !== 1'b1 || addr !== 16'h0040) begin
      errors++; $display("FAIL branch_redirect got=%b/%h exp=1/0040", req, addr);
    end
    IR_READY = 1'b0;
    IMEM_ACK = 1'b1;
    IMEM_RDATA = 16'h0123;
    step();
    IMEM_ACK = 1'b0;
    checks++; if (ir !== 16'h0123 || ir_valid !== 1'b1 || pc_out !== 16'h0040) begin
      errors++; $display("FAIL branch_fetch got=%h/%b/%h exp=0123/1/0040", ir, ir_valid, pc_out);
    end
    checks++; if (addr !== 16'h0041) begin errors++; $display("FAIL branch_pc_inc got=%h exp=0041", addr); end
    IR_READY = 1'b1;
    BR_TAKE = 1'b1;
    BR_TARGET = 16'h0080;
    step();
    BR_TAKE = 1'b0;
    checks++; if (ir_valid !== 1'b0 || req !== 1'b1 || addr !== 16'h0080 || ir !== 16'h0123) begin
      errors++; $display("FAIL branch_flush got=%b/%b/%h/%h exp=0/1/0080/0123", ir_valid, req, addr, ir);
    end
  endtask

`ifdef CPU16_FETCH_HALT_EN
  task automatic test_halt();
    IMEM_ACK = 1'b1;
    IMEM_RDATA = 16'hF000;
    step();
    IMEM_ACK = 1'b0;
    checks++; if (ir !== 16'hF000 || ir_valid !== 1'b1) begin
      errors++; $display("FAIL halt_fetch got=%h/%b exp=F000/1", ir, ir_valid);
    end
    step();
    IMEM_ACK = 1'b1;
    IMEM_RDATA = 16'h7777;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (req !== 1'b0 || ir_valid !== 1'b0 || addr !== 16'h0081 || ir !== 16'hF000) begin
        errors++; $display("FAIL halt_frozen[%0d] got=%b/%b/%h/%h exp=0/0/0081/F000", i, req, ir_valid, addr, ir);
      end
    end
    IMEM_ACK = 1'b0;
    BR_TAKE = 1'b1;
    BR_TARGET = 16'h0010;
    step();
    BR_TAKE = 1'b0;
    checks++; if (req !== 1'b1 || addr !== 16'h0010) begin
      errors++; $display("FAIL halt_resume got=%b/%h exp=1/0010", req, addr);
    end
    IMEM_ACK = 1'b1;
    IMEM_RDATA = 16'h0555;
    step();
    IMEM_ACK = 1'b0;
    checks++; if (ir !== 16'h0555 || pc_out !== 16'h0010) begin
      errors++; $display("FAIL halt_refetch got=%h/%h exp=0555/0010", ir, pc_out);
    end
    step();
  endtask
`else
  task automatic test_opcode_f();
    IMEM_ACK = 1'b1;
    IMEM_RDATA = 16'hF000;
    step();
    IMEM_ACK = 1'b0;
    checks++; if (ir !== 16'hF000 || ir_valid !== 1'b1 || pc_out !== 16'h0080) begin
      errors++; $display("FAIL opf_fetch got=%h/%b/%h exp=F000/1/0080", ir, ir_valid, pc_out);
    end
    step();
    checks++; if (req !== 1'b1 || addr !== 16'h0081 || ir_valid !== 1'b0) begin
      errors++; $display("FAIL opf_continue got=%b/%h/%b exp=1/0081/0", req, addr, ir_valid);
    end
  endtask
`endif

  task automatic test_reset_mid_and_wrap();
    RST_N = 1'b0;
    IMEM_ACK = 1'b1;
    IMEM_RDATA = 16'hDEAD;
    #1;
    checks++; if (req !== 1'b0 || w_req !== 1'b0) begin
      errors++; $display("FAIL midreset_req got=%b/%b exp=0/0", req, w_req);
    end
    step();
    checks++; if (ir !== 16'h0000 || ir_valid !== 1'b0 || addr !== 16'h0000 || pc_out !== 16'h0000) begin
      errors++; $display("FAIL midreset_state got=%h/%b/%h/%h exp=0000/0/0000/0000", ir, ir_valid, addr, pc_out);
    end
    IMEM_ACK = 1'b0;
    RST_N = 1'b1;
    #1;
    checks++; if (w_req !== 1'b1 || w_addr !== 16'hFFFF) begin
      errors++; $display("FAIL wrap_first_req got=%b/%h exp=1/FFFF", w_req, w_addr);
    end
    IMEM_ACK = 1'b1;
    IMEM_RDATA = 16'h1111;
    step();
    IMEM_ACK = 1'b0;
    checks++; if (w_addr !== 16'h0000) begin errors++; $display("FAIL wrap_addr got=%h exp=0000", w_addr); end
    checks++; if (w_pc_out !== 16'hFFFF || w_ir !== 16'h1111 || w_ir_valid !== 1'b1) begin
      errors++; $display("FAIL wrap_ir got=%h/%h/%b exp=FFFF/1111/1", w_pc_out, w_ir, w_ir_valid);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_wait_state();
    test_stall();
    test_branch();
`ifdef CPU16_FETCH_HALT_EN
    test_halt();
`else
    test_opcode_f();
`endif
    test_reset_mid_and_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu16_fetch.md
Name: cpu16_fetch

Overview:
Instruction fetch stage of the 16-bit CPU, directly upstream of cpu16_decode. It holds the program counter and issues word reads to instruction memory over a req/ack handshake. It latches the returned word into IR and presents it to decode with a valid/ready handshake. A taken branch from execute redirects it.

Parameters:
PC_W, 16, program counter and IMEM address width.
RESET_PC, 16'h0000, PC value loaded at reset.
PC_STEP, 1, PC increment per fetched instruction (word addressing).

Ports:
CLK  input  1  clock; all state updates on rising edge.
RST_N  input  1  synchronous active-low reset.
IMEM_REQ  output  1  read request to instruction memory.
IMEM_ADDR  output  PC_W  read address; always equals PC.
IMEM_ACK  input  1  memory returns data this cycle; ignored unless IMEM_REQ=1.
IMEM_RDATA  input  16  instruction word, valid when IMEM_ACK=1.
IR  output  16  instruction register, feeds cpu16_decode.IR.
IR_VALID  output  1  IR holds an unconsumed instruction.
IR_READY  input  1  decode accepts IR this cycle.
BR_TAKE  input  1  redirect request from execute.
BR_TARGET  input  PC_W  redirect address.
PC_OUT  output  PC_W  address of the instruction currently in IR, for PC-relative ops.

Behaviour:
- States: S_REQ (request outstanding), S_HOLD (IR valid, waiting for decode), S_HALT (only with the optional feature).
- Reset (RST_N=0 at an edge) gives PC=RESET_PC, IR=16'h0000, IR_VALID=0, PC_OUT=RESET_PC, state=S_REQ.
- IMEM_REQ=1 combinationally in S_REQ, 0 otherwise. The first request is therefore asserted in the cycle after reset release.
- IMEM_ADDR=PC at all times.
- S_REQ with IMEM_ACK=1 (and no branch):
  - IR<=IMEM_RDATA, IR_VALID<=1, PC_OUT<=PC, PC<=PC+PC_STEP, go to S_HOLD.
  - Latency: ACK in cycle n gives IR_VALID=1 in cycle n+1.
- S_REQ with IMEM_ACK=0: hold. REQ and ADDR stay stable until ACK.
- S_HOLD with IR_VALID & IR_READY: IR_VALID<=0, go to S_REQ. Throughput is at most one instruction per 2 cycles with a zero-wait memory.
- S_HOLD with IR_READY=0: IR, IR_VALID and PC_OUT are held unchanged indefinitely.
- BR_TAKE=1 in any state:
  - PC<=BR_TARGET, IR_VALID<=0, state<=S_REQ.
  - An ACK in the same cycle is discarded: IR is not updated and PC does not increment.
  - A handshake in the same cycle is treated as a flush.
- Priority: reset > BR_TAKE > ACK/handshake.
- PC arithmetic is modulo 2^PC_W. PC=16'hFFFF with PC_STEP=1 wraps to 16'h0000 with no flag.
- Reset mid-request: state returns to S_REQ with IMEM_REQ=0 during the reset cycle. Any later ACK for the abandoned request is ignored if IMEM_REQ=0.
- IR is never modified while IR_VALID=1 except by reset.

Optional Feature:
Macro: CPU16_FETCH_HALT_EN.
- Defined:
  - When an instruction with IR[15:12]=4'hF is accepted by decode (IR_VALID & IR_READY), the state goes to S_HALT.
  - S_HALT: IMEM_REQ=0, IR_VALID=0, PC frozen.
  - Only BR_TAKE (resumes at BR_TARGET) or reset leaves S_HALT.
- Undefined: S_HALT does not exist. Opcode 4'hF is fetched and passed on like any other word.

Test Plan:
1. Reset with RST_N=0 for 2 cycles, RESET_PC=0 -> IR=0000, IR_VALID=0, IMEM_REQ=0 during reset; IMEM_REQ=1, IMEM_ADDR=0000 the cycle after release.
2. Zero-wait memory returning 02A2, 0222, 02C2, 02E2 at addresses 0..3, IR_READY=1 -> IR shows each word in order with IR_VALID pulses every 2 cycles; PC_OUT=0,1,2,3.
3. ACK delayed 3 cycles -> IMEM_REQ/IMEM_ADDR stable across the wait; IR_VALID rises exactly 1 cycle after ACK.
4. IR_READY=0 for 5 cycles with IR=02A2 -> IR, IR_VALID=1 and PC_OUT held; no new IMEM_REQ until the handshake completes.
5. BR_TAKE=1, BR_TARGET=0040 in the same cycle as ACK for address 0005 -> data dropped, IR_VALID=0; next request at IMEM_ADDR=0040; next IR comes from 0040 with PC_OUT=0040.
6. RESET_PC=FFFF -> after the first fetch, IMEM_ADDR=0000. With CPU16_FETCH_HALT_EN, word F000 accepted -> IMEM_REQ stays 0 until BR_TAKE with target 0010, after which fetching resumes at 0010.
